// File: rtl/dds_wave_gen.sv
// -----------------------------------------------------------------------------
// dds_wave_gen
//
// Direct-digital-synthesis waveform generator. A phase accumulator advanced by
// a run-time frequency tuning word (FTW) feeds a selectable waveform stage
// (sine table, square, sawtooth, triangle). A second stage scales the sample
// about midscale by (amp+1)/256. The output is offset binary and registered.
//
// Pipeline (enabled edges only):
//   edge k   : acc_q  <= acc + ftw_active, wrap_q <= carry out
//   edge k+1 : wave_q <= wave(acc_q, mode)
//   edge k+2 : Q      <= M + ((wave_q - M) * (amp+1)) >>> 8
//
// FTW changes are staged in a pending register and applied on the edge whose
// add wraps the accumulator, so the new frequency starts at phase zero. A
// stopped generator (active FTW of zero) never wraps, so loads then go straight
// into the active word.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset, overrides all other inputs
//   en        in   advance enable; 0 holds the whole pipeline
//   ftw_in    in   PHASE_W  new tuning word
//   ftw_load  in   capture ftw_in this edge (independent of en)
//   mode      in   2  0 sine, 1 square, 2 sawtooth, 3 triangle
//   amp       in   8  amplitude, gain (amp+1)/256
//   Q         out  OUT_W  sample, offset binary, midscale 2^(OUT_W-1)
//   valid     out  high once the pipeline holds a real sample
//   sync      out  one-cycle pulse on the first sample after a wrap
// -----------------------------------------------------------------------------
module dds_wave_gen #(
   parameter int unsigned         PHASE_W     = 24,
   parameter int unsigned         OUT_W       = 8,
   parameter int unsigned         LUT_AW      = 8,
   parameter logic [PHASE_W-1:0]  DEFAULT_FTW = 24'h010000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] ftw_in,
   input  logic               ftw_load,
   input  logic [1:0]         mode,
   input  logic [7:0]         amp,
   output logic [OUT_W-1:0]   Q,
   output logic               valid,
   output logic               sync
);

   localparam int unsigned LUT_N  = 2 ** LUT_AW;
   localparam int unsigned MID    = 2 ** (OUT_W - 1);
   localparam int unsigned PROD_W = OUT_W + 11;

   localparam logic [OUT_W-1:0] MID_V = {1'b1, {(OUT_W-1){1'b0}}};

   // Parameter legality: the triangle tap needs OUT_W bits below the MSB and
   // the sine address is taken from the top LUT_AW accumulator bits.
   if (PHASE_W < OUT_W + 1) begin : g_chk_pw_out
      $error("dds_wave_gen: PHASE_W must be at least OUT_W+1");
   end
   if (PHASE_W < LUT_AW) begin : g_chk_pw_lut
      $error("dds_wave_gen: PHASE_W must be at least LUT_AW");
   end

   // Sine table entry: M + round((M-1) * sin(2*pi*k/LUT_N)), rounding half
   // away from zero. Only ever called with constant arguments, so the whole
   // table folds to constants.
   function automatic logic [OUT_W-1:0] sine_entry(input int unsigned k);
      real ang;
      real v;
      int  r;
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N);
      v   = real'(MID - 1) * $sin(ang);
      if (v >= 0.0) begin
         r = $rtoi(v + 0.5);
      end else begin
         r = -$rtoi(0.5 - v);
      end
      return OUT_W'(int'(MID) + r);
   endfunction

   logic [OUT_W-1:0] sine_lut_s [LUT_N];

   for (genvar k = 0; k < LUT_N; k++) begin : g_lut
      assign sine_lut_s[k] = sine_entry(k);
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PHASE_W-1:0] acc_q,        acc_d;
   logic               wrap_q,       wrap_d;
   logic [PHASE_W-1:0] ftw_active_q, ftw_active_d;
   logic [PHASE_W-1:0] ftw_pend_q,   ftw_pend_d;
   logic               pend_q,       pend_d;
   logic [OUT_W-1:0]   wave_q,       wave_d;
   logic               wrap_pipe_q,  wrap_pipe_d;
   logic               valid_pipe_q, valid_pipe_d;
   logic [OUT_W-1:0]   q_q,          q_d;
   logic               valid_q,      valid_d;
   logic               sync_q,       sync_d;

   logic [PHASE_W:0]   sum_s;
   logic [OUT_W-1:0]   tri_s;
   logic [OUT_W-1:0]   wave_sel_s;
   logic [9:0]         gain_s;
   logic signed [OUT_W:0]    dev_s;
   logic signed [PROD_W-1:0] dev_ext_s;
   logic signed [PROD_W-1:0] gain_ext_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [PROD_W-1:0] mid_ext_s;
   logic [OUT_W-1:0]   scaled_s;

   // Accumulator add with carry; the carry is the wrap flag.
   assign sum_s = {1'b0, acc_q} + {1'b0, ftw_active_q};

   // Accumulator advance and tuning-word bookkeeping.
   always_comb begin
      acc_d        = acc_q;
      wrap_d       = wrap_q;
      ftw_active_d = ftw_active_q;
      ftw_pend_d   = ftw_pend_q;
      pend_d       = pend_q;

      if (en) begin
         acc_d  = sum_s[PHASE_W-1:0];
         wrap_d = sum_s[PHASE_W];
         // Apply the staged word on the wrapping edge; the next add uses it.
         if (pend_q && sum_s[PHASE_W]) begin
            ftw_active_d = ftw_pend_q;
            pend_d       = 1'b0;
         end else begin
            ftw_active_d = ftw_active_q;
         end
      end else begin
         acc_d  = acc_q;
         wrap_d = wrap_q;
      end

      // A load that coincides with an apply overrides only the pending slot,
      // because the apply consumed the old pending value above.
      if (ftw_load) begin
         if (ftw_active_q == {PHASE_W{1'b0}}) begin
            // A stopped accumulator never wraps: write the active word directly.
            ftw_active_d = ftw_in;
         end else begin
            ftw_pend_d = ftw_in;
            pend_d     = 1'b1;
         end
      end else begin
         ftw_pend_d = ftw_pend_q;
      end
   end

   // Triangle ramp: one bit below the MSB, mirrored on the second half period.
   assign tri_s = acc_q[PHASE_W-2 -: OUT_W];

   // Waveform selection from the current accumulator value.
   always_comb begin
      wave_sel_s = MID_V;
      case (mode)
         2'd0: wave_sel_s = sine_lut_s[acc_q[PHASE_W-1 -: LUT_AW]];
         2'd1: begin
            if (acc_q[PHASE_W-1]) begin
               wave_sel_s = {OUT_W{1'b0}};
            end else begin
               wave_sel_s = {OUT_W{1'b1}};
            end
         end
         2'd2: wave_sel_s = acc_q[PHASE_W-1 -: OUT_W];
         2'd3: begin
            if (acc_q[PHASE_W-1]) begin
               wave_sel_s = ~tri_s;
            end else begin
               wave_sel_s = tri_s;
            end
         end
         default: wave_sel_s = MID_V;
      endcase
   end

   // Amplitude scaling about midscale. The deviation lies in [-M, M-1] and the
   // gain is at most 1, so the floor-shifted result always fits OUT_W after
   // re-adding M; the truncating cast is therefore lossless.
   always_comb begin
      gain_s     = {2'b00, amp} + 10'd1;
      dev_s      = $signed({1'b0, wave_q}) - $signed({1'b0, MID_V});
      dev_ext_s  = {{10{dev_s[OUT_W]}}, dev_s};
      gain_ext_s = $signed({{(OUT_W+1){1'b0}}, gain_s});
      prod_s     = dev_ext_s * gain_ext_s;
      mid_ext_s  = $signed({{(PROD_W-OUT_W){1'b0}}, MID_V});
      scaled_s   = OUT_W'((prod_s >>> 4'd8) + mid_ext_s);
   end

   // Output pipeline: advances only on enabled edges; sync is a strobe and
   // drops on any stalled cycle.
   always_comb begin
      wave_d       = wave_q;
      wrap_pipe_d  = wrap_pipe_q;
      valid_pipe_d = valid_pipe_q;
      q_d          = q_q;
      valid_d      = valid_q;
      sync_d       = 1'b0;
      if (en) begin
         wave_d       = wave_sel_s;
         wrap_pipe_d  = wrap_q;
         valid_pipe_d = 1'b1;
         q_d          = scaled_s;
         valid_d      = valid_pipe_q;
         sync_d       = wrap_pipe_q;
      end else begin
         sync_d       = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= {PHASE_W{1'b0}};
         wrap_q       <= 1'b0;
         ftw_active_q <= DEFAULT_FTW;
         ftw_pend_q   <= {PHASE_W{1'b0}};
         pend_q       <= 1'b0;
         wave_q       <= MID_V;
         wrap_pipe_q  <= 1'b0;
         valid_pipe_q <= 1'b0;
         q_q          <= MID_V;
         valid_q      <= 1'b0;
         sync_q       <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         wrap_q       <= wrap_d;
         ftw_active_q <= ftw_active_d;
         ftw_pend_q   <= ftw_pend_d;
         pend_q       <= pend_d;
         wave_q       <= wave_d;
         wrap_pipe_q  <= wrap_pipe_d;
         valid_pipe_q <= valid_pipe_d;
         q_q          <= q_d;
         valid_q      <= valid_d;
         sync_q       <= sync_d;
      end
   end

   assign Q     = q_q;
   assign valid = valid_q;
   assign sync  = sync_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_wave_gen
//
// Directed bench for dds_wave_gen (default parameters). A behavioural model
// keeps the per-edge history of accumulator values, wrap flags, mode and amp,
// and forms the expected output straight from the timing rules:
//   Q after enabled edge m = scale(wave(acc_{m-2}, mode at edge m-1), amp at m)
//   sync after edge m      = wrap flag of acc_{m-2}
// A compare process checks every cycle; hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_dds_wave_gen;

   localparam int TWO24 = 16777216;
   localparam int HALF  = 8388608;
   localparam int DEF_FTW = 65536;

   logic        clk;
   logic        rst;
   logic        en;
   logic [23:0] ftw_in;
   logic        ftw_load;
   logic [1:0]  mode;
   logic [7:0]  amp;
   logic [7:0]  Q;
   logic        valid;
   logic        sync;

   int total = 0;
   int bad   = 0;

   dds_wave_gen #(
      .PHASE_W(24), .OUT_W(8), .LUT_AW(8), .DEFAULT_FTW(24'h010000)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ftw_in(ftw_in), .ftw_load(ftw_load),
      .mode(mode), .amp(amp), .Q(Q), .valid(valid), .sync(sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model --
   bit mdl_on = 1'b0;
   int m_acc, m_ftw, m_pval;
   bit m_pend;
   int acc_h[$];
   bit wrap_h[$];
   int mode_h[$];
   int amp_h[$];
   int exp_q;
   bit exp_valid, exp_sync;

   function automatic int wave_of(input int a, input int md);
      int t;
      case (md)
         0: return 128 + int'(127.0 * $sin(2.0 * 3.14159265358979323846 * real'(a / 65536) / 256.0));
         1: return (a < HALF) ? 255 : 0;
         2: return a / 65536;
         default: begin
            t = (a / 32768) % 256;
            return (a >= HALF) ? 255 - t : t;
         end
      endcase
   endfunction

   function automatic int scale(input int w, input int a);
      int p, qt;
      p  = (w - 128) * (a + 1);
      qt = p / 256;
      if (p < 0 && (p % 256) != 0) qt = qt - 1;
      return 128 + qt;
   endfunction

   initial begin : model
      int n, m, old_ftw;
      bit w;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_acc = 0; m_ftw = DEF_FTW; m_pend = 1'b0; m_pval = 0;
            acc_h.delete(); wrap_h.delete(); mode_h.delete(); amp_h.delete();
            acc_h.push_back(0); wrap_h.push_back(1'b0);
            mode_h.push_back(0); amp_h.push_back(0);
            exp_q = 128; exp_valid = 1'b0; exp_sync = 1'b0;
            mdl_on = 1'b1;
         end else if (mdl_on) begin
            old_ftw = m_ftw;
            if (en) begin
               n = m_acc + m_ftw;
               w = (n >= TWO24);
               if (w) n = n - TWO24;
               m_acc = n;
               acc_h.push_back(n); wrap_h.push_back(w);
               mode_h.push_back(int'(mode)); amp_h.push_back(int'(amp));
               if (w && m_pend) begin
                  m_ftw = m_pval; m_pend = 1'b0;
               end
               m = acc_h.size() - 1;
               exp_valid = (m >= 2);
               exp_sync  = (m >= 2) ? wrap_h[m-2] : 1'b0;
               exp_q     = (m >= 2) ? scale(wave_of(acc_h[m-2], mode_h[m-1]), amp_h[m]) : 128;
            end else begin
               exp_sync = 1'b0;
            end
            if (ftw_load) begin
               if (old_ftw == 0) m_ftw = int'(ftw_in);
               else begin
                  m_pval = int'(ftw_in); m_pend = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (mdl_on) begin
            chk("model_q", {24'd0, Q}, exp_q);
            chk("model_valid", {31'd0, valid}, {31'd0, exp_valid});
            chk("model_sync", {31'd0, sync}, {31'd0, exp_sync});
         end
      end
   end

   // ------------------------------------------------------------ stimulus --
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; en = 1'b1; ftw_in = 24'h0; ftw_load = 1'b0;
      mode = 2'd0; amp = 8'd255;
      tick(); tick();
      chk("reset_q", {24'd0, Q}, 128);
      chk("reset_valid", {31'd0, valid}, 0);
      chk("reset_sync", {31'd0, sync}, 0);
      rst = 1'b0;

      // Sine, unity gain: latency, peak, trough, period.
      for (int e = 1; e <= 260; e++) begin
         tick();
         if (e == 1)   begin chk("sin_e1_valid", {31'd0, valid}, 0); chk("sin_e1_q", {24'd0, Q}, 128); end
         if (e == 2)   begin chk("sin_e2_valid", {31'd0, valid}, 1); chk("sin_e2_q", {24'd0, Q}, 128); end
         if (e == 66)  chk("sin_peak", {24'd0, Q}, 255);
         if (e == 194) chk("sin_trough", {24'd0, Q}, 1);
         if (e == 258) begin chk("sin_period", {24'd0, Q}, 128); chk("sin_sync", {31'd0, sync}, 1); end
      end

      // Sawtooth with a phase-continuous FTW change loaded at edge 100.
      mode = 2'd2; do_reset();
      for (int e = 1; e <= 400; e++) begin
         ftw_load = (e == 100); ftw_in = 24'h020000;
         tick();
         if (e == 99)  chk("saw_e99", {24'd0, Q}, 97);
         if (e == 257) begin chk("saw_top", {24'd0, Q}, 255); chk("saw_top_sync", {31'd0, sync}, 0); end
         if (e == 258) begin chk("saw_wrap", {24'd0, Q}, 0); chk("saw_wrap_sync", {31'd0, sync}, 1); end
         if (e == 259) chk("ftw_step2", {24'd0, Q}, 2);
         if (e == 385) begin chk("ftw_top", {24'd0, Q}, 254); chk("ftw_top_sync", {31'd0, sync}, 0); end
         if (e == 386) begin chk("ftw_wrap", {24'd0, Q}, 0); chk("ftw_sync128", {31'd0, sync}, 1); end
      end
      ftw_load = 1'b0;

      // Square with amp 127, then amp 0.
      mode = 2'd1; amp = 8'd127; do_reset();
      for (int e = 1; e <= 386; e++) begin
         if (e == 259) amp = 8'd0;
         tick();
         if (e == 2)   chk("sq127_hi_first", {24'd0, Q}, 191);
         if (e == 129) chk("sq127_hi_last", {24'd0, Q}, 191);
         if (e == 130) chk("sq127_lo_first", {24'd0, Q}, 64);
         if (e == 257) chk("sq127_lo_last", {24'd0, Q}, 64);
         if (e == 258) chk("sq127_hi_again", {24'd0, Q}, 191);
         if (e == 259) chk("sq0_hi", {24'd0, Q}, 128);
         if (e == 386) chk("sq0_lo", {24'd0, Q}, 127);
      end

      // Enable stall at Q = 50 with a load during the stall.
      mode = 2'd2; amp = 8'd255; do_reset();
      for (int e = 1; e <= 52; e++) tick();
      chk("stall_entry", {24'd0, Q}, 50);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ftw_load = (i == 4); ftw_in = 24'h020000;
         tick();
         chk("stall_q", {24'd0, Q}, 50);
         chk("stall_sync", {31'd0, sync}, 0);
      end
      ftw_load = 1'b0; en = 1'b1;
      for (int e = 53; e <= 260; e++) begin
         tick();
         if (e == 53)  chk("stall_resume", {24'd0, Q}, 51);
         if (e == 258) chk("stall_wrap_sync", {31'd0, sync}, 1);
         if (e == 259) chk("stall_load_applied", {24'd0, Q}, 2);
      end

      // Reset mid-run discards a pending load.
      do_reset();
      for (int e = 1; e <= 202; e++) begin
         ftw_load = (e == 150); ftw_in = 24'h020000;
         tick();
      end
      ftw_load = 1'b0;
      chk("pre_reset_q", {24'd0, Q}, 200);
      rst = 1'b1;
      tick();
      chk("midrst_q", {24'd0, Q}, 128);
      chk("midrst_valid", {31'd0, valid}, 0);
      rst = 1'b0;
      for (int e = 1; e <= 300; e++) begin
         tick();
         if (e == 258) chk("midrst_sync", {31'd0, sync}, 1);
         if (e == 259) chk("pend_discarded", {24'd0, Q}, 1);
      end

      // Zero FTW applied at the wrap freezes the output.
      for (int e = 301; e <= 540; e++) begin
         ftw_load = (e == 301); ftw_in = 24'h000000;
         tick();
         if (e == 513) chk("zero_last_top", {24'd0, Q}, 255);
         if (e == 514) chk("zero_wrap_sync", {31'd0, sync}, 1);
         if (e == 540) begin chk("zero_frozen", {24'd0, Q}, 0); chk("zero_nosync", {31'd0, sync}, 0); end
      end
      // Direct load into a stopped accumulator while disabled.
      en = 1'b0; ftw_in = 24'h010000; ftw_load = 1'b1;
      tick();
      ftw_load = 1'b0;
      chk("zero_load_hold", {24'd0, Q}, 0);
      en = 1'b1;
      tick(); tick(); tick();
      chk("zero_resume", {24'd0, Q}, 1);

      // Triangle.
      mode = 2'd3; amp = 8'd255; do_reset();
      for (int e = 1; e <= 200; e++) begin
         tick();
         if (e == 66)  chk("tri_mid_rise", {24'd0, Q}, 128);
         if (e == 129) chk("tri_top", {24'd0, Q}, 254);
         if (e == 194) chk("tri_mid_fall", {24'd0, Q}, 127);
      end

      // Mixed modes, gains, stalls and an odd tuning word (model-checked).
      ftw_in = 24'h01F3A7; ftw_load = 1'b1;
      tick();
      ftw_load = 1'b0;
      for (int i = 0; i < 600; i++) begin
         mode = 2'((i / 37) % 4);
         amp  = 8'((i * 53) % 256);
         en   = ((i % 11) != 5);
         tick();
      end
      en = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
